// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract done one N-bit slice per cycle, LSW first, through a single adder slice.
// A carry register links the slices; the flags are captured alongside the final slice write.
module adder_seq_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic               sub,
  input  logic               sign,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] result,
  output logic               cout,
  output logic               ovf
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q, sign_q, carry;
  logic [IW-1:0] idx;
  logic [N-1:0]  a_sl, b_sl, sum_sl;
  logic          c_sl, accept, last;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(WORDS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Subtract is A + ~B + 1; the +1 enters through the carry register seeded with sub.
  assign a_sl = a_q[idx*N +: N];
  assign b_sl = b_q[idx*N +: N] ^ {N{sub_q}};
  assign {c_sl, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, carry};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sign_q <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        sub_q  <= sub;
        sign_q <= sign;
        carry  <= sub;
        idx    <= '0;
        cout   <= 1'b0;
        ovf    <= 1'b0;
      end else if (state == RUN) begin
        result[idx*N +: N] <= sum_sl;
        carry              <= c_sl;
        idx                <= last ? '0 : idx + 1'b1;
        // The MSB slice is in flight on the last RUN cycle, so its sign bits decide overflow.
        if (last) begin
          cout <= c_sl;
          ovf  <= sign_q & (a_sl[N-1] == b_sl[N-1]) & (sum_sl[N-1] != a_sl[N-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (N=8, WORDS=4); cycle k counts edges since start was driven.
module tb_adder_seq_ctrl;
  localparam int N = 8, WORDS = 4, W = N * WORDS;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, sign = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  logic         busy, done, cout, ovf;
  int           n_chk = 0, n_fail = 0;

  adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .sub(sub), .sign(sign),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drives start for one cycle; returns in cycle 1 of the operation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic g);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; sign = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle at which done was seen (20 means timeout).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_chk++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {cout, ovf}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_wrap;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL unsigned_busy c%0d: got busy=%b done=%b want busy=1 done=0", c, busy, done);
      end
      @(negedge clk);
    end
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL unsigned_done c5: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    n_chk++; if (result !== 32'h0000_0000) begin n_fail++; $display("FAIL unsigned_result: got %h want 00000000", result); end
    n_chk++; if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL unsigned_flags: got cout,ovf=%b want 10", {cout, ovf}); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL unsigned_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
    n_chk++; if (result !== 32'h0000_0000 || cout !== 1'b1) begin
      n_fail++; $display("FAIL unsigned_hold: got %h cout=%b want 00000000 cout=1", result, cout);
    end
  endtask

  task automatic test_signed_add_ovf;
    int cyc;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(cyc);
    n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL sadd_latency: got cycle %0d want 5", cyc); end
    n_chk++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL sadd_result: got %h want 80000000", result); end
    n_chk++; if ({cout, ovf} !== 2'b01) begin n_fail++; $display("FAIL sadd_flags: got cout,ovf=%b want 01", {cout, ovf}); end
    @(negedge clk);
  endtask

  task automatic test_sub_borrow;
    int cyc;
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    wait_done(cyc);
    n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL sub_latency: got cycle %0d want 5", cyc); end
    n_chk++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result: got %h want fffffffe", result); end
    n_chk++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL sub_flags: got cout,ovf=%b want 00", {cout, ovf}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    wait_done(cyc);
    n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL b2b_lat1: got cycle %0d want 5", cyc); end
    n_chk++; if (result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL b2b_result1: got %h want 7fffffff", result); end
    n_chk++; if ({cout, ovf} !== 2'b11) begin n_fail++; $display("FAIL b2b_flags1: got cout,ovf=%b want 11", {cout, ovf}); end
    // Still in the DONE cycle: hold start for the second operation.
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0; sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b want 1 0", busy, done);
    end
    n_chk++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL b2b_flag_clear: got cout,ovf=%b want 00", {cout, ovf}); end
    wait_done(cyc);
    n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL b2b_lat2: got cycle %0d want 5", cyc); end
    n_chk++; if (result !== 32'h2345_6789) begin n_fail++; $display("FAIL b2b_result2: got %h want 23456789", result); end
    n_chk++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags2: got cout,ovf=%b want 00", {cout, ovf}); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int dones = 0, at = 0;
    logic [W-1:0] res = '0;
    issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin dones++; at = cyc; res = result; end
      start = (cyc == 2 || cyc == 3);
      op_a  = (cyc == 2) ? 32'hAAAA_AAAA : 32'h5555_5555;
      op_b  = 32'h0F0F_0F0F; sub = 1'b1; sign = 1'b1;
    end
    start = 1'b0;
    n_chk++; if (dones != 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", dones); end
    n_chk++; if (at != 5) begin n_fail++; $display("FAIL ignore_latency: got cycle %0d want 5", at); end
    n_chk++; if (res !== 32'h0000_0030) begin n_fail++; $display("FAIL ignore_result: got %h want 00000030", res); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    issue(32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (result[7:0] !== 8'h14) begin n_fail++; $display("FAIL rstmid_partial: got %h want 14", result[7:0]); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    n_chk++; if (result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_data: got %h cout=%b ovf=%b want 0", result, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(cyc);
    n_chk++; if (cyc != 5) begin n_fail++; $display("FAIL rstmid_lat: got cycle %0d want 5", cyc); end
    n_chk++; if (result !== 32'h0000_0100 || {cout, ovf} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_after: got %h cout,ovf=%b want 00000100 00", result, {cout, ovf});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_unsigned_wrap;
    test_signed_add_ovf;
    test_sub_borrow;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
